// File: rtl/evm_ballot_unit.sv
// Electronic-voting tally: poll FSM, per-candidate saturating counters, multi-button
// rejection and a sequential winner/tie scan. Define EVM_SYNC_EN for a 2-flop vote synchroniser.
module evm_ballot_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != {W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

module evm_ballot_unit #(
    parameter int N_CAND = 4,
    parameter int CNT_W  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       open_poll,
    input  logic                       close_poll,
    input  logic                       voter_en,
    input  logic [N_CAND-1:0]          vote,
    output logic [N_CAND*CNT_W-1:0]    counts,
    output logic [CNT_W-1:0]           invalid_cnt,
    output logic [1:0]                 state,
    output logic                       ballot_ready,
    output logic                       vote_ack,
    output logic                       vote_rej,
    output logic [$clog2(N_CAND)-1:0]  winner,
    output logic                       tie,
    output logic                       result_valid
);
    localparam int IDX_W = $clog2(N_CAND);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_OPEN   = 2'd1,
        S_ARMED  = 2'd2,
        S_CLOSED = 2'd3
    } state_e;

    state_e                          state_q, state_d;
    logic [N_CAND-1:0]               vin, vote_q, rise;
    logic [N_CAND-1:0][CNT_W-1:0]    cnt;
    logic                            clr, ballot, one_hot, valid_vote, bad_vote;
    logic                            ack_q, rej_q;
    logic [IDX_W-1:0]                scan_q, scan_d, win_q, win_d;
    logic [CNT_W-1:0]                max_q, max_d, cur;
    logic                            tie_q, tie_d, rv_q, rv_d;

`ifdef EVM_SYNC_EN
    logic [N_CAND-1:0] sync1_q, sync2_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= vote;
            sync2_q <= sync1_q;
        end
    end
    assign vin = sync2_q;
`else
    assign vin = vote;
`endif

    // Edge history runs in every state so a button held across arming never counts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) vote_q <= '0;
        else        vote_q <= vin;
    end

    assign rise    = vin & ~vote_q;
    assign one_hot = (vin != '0) && ((vin & (vin - 1'b1)) == '0);

    always_comb begin
        state_d = state_q;
        clr     = 1'b0;
        ballot  = 1'b0;
        case (state_q)
            S_IDLE:   if (open_poll) begin clr = 1'b1; state_d = S_OPEN; end
            S_OPEN:   if (close_poll) state_d = S_CLOSED;
                      else if (voter_en) state_d = S_ARMED;
            S_ARMED:  if (close_poll) state_d = S_CLOSED;
                      else if (rise != '0) begin ballot = 1'b1; state_d = S_OPEN; end
            S_CLOSED: if (open_poll) begin clr = 1'b1; state_d = S_OPEN; end
            default:  state_d = S_IDLE;
        endcase
    end

    assign valid_vote = ballot & one_hot;
    assign bad_vote   = ballot & ~one_hot;

    for (genvar i = 0; i < N_CAND; i++) begin : g_lane
        evm_ballot_cnt #(.W(CNT_W)) u_cnt (
            .clk   (clk),
            .rst_n (reset),
            .clr_i (clr),
            .inc_i (valid_vote & vin[i]),
            .cnt_o (cnt[i])
        );
    end

    evm_ballot_cnt #(.W(CNT_W)) u_invalid (
        .clk   (clk),
        .rst_n (reset),
        .clr_i (clr),
        .inc_i (bad_vote),
        .cnt_o (invalid_cnt)
    );

    // One candidate per cycle; strict '>' keeps the lowest index on equal counts.
    always_comb begin
        scan_d = scan_q;
        max_d  = max_q;
        win_d  = win_q;
        tie_d  = tie_q;
        rv_d   = rv_q;
        cur    = cnt[scan_q];
        if (clr) begin
            scan_d = '0;
            max_d  = '0;
            win_d  = '0;
            tie_d  = 1'b0;
            rv_d   = 1'b0;
        end else if (state_q == S_CLOSED && !rv_q) begin
            if (scan_q == '0) begin
                max_d = cur;
                win_d = '0;
                tie_d = 1'b0;
            end else if (cur > max_q) begin
                max_d = cur;
                win_d = scan_q;
                tie_d = 1'b0;
            end else if (cur == max_q) begin
                tie_d = 1'b1;
            end
            if (scan_q == IDX_W'(N_CAND - 1)) rv_d = 1'b1;
            else                              scan_d = scan_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            rej_q   <= 1'b0;
            scan_q  <= '0;
            max_q   <= '0;
            win_q   <= '0;
            tie_q   <= 1'b0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= valid_vote;
            rej_q   <= bad_vote;
            scan_q  <= scan_d;
            max_q   <= max_d;
            win_q   <= win_d;
            tie_q   <= tie_d;
            rv_q    <= rv_d;
        end
    end

    assign counts       = cnt;
    assign state        = state_q;
    assign ballot_ready = (state_q == S_ARMED);
    assign vote_ack     = ack_q;
    assign vote_rej     = rej_q;
    assign winner       = win_q;
    assign tie          = tie_q;
    assign result_valid = rv_q;
endmodule

// File: tb/tb_evm_ballot_unit.sv
// Bench for evm_ballot_unit (N_CAND=4, CNT_W=4): vector table, corner sequences and
// randomized polls checked against an array-based tally model.
module tb_evm_ballot_unit;
    localparam int N = 4;
    localparam int W = 4;
    localparam int SAT = (1 << W) - 1;
`ifdef EVM_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           open_poll = 1'b0, close_poll = 1'b0, voter_en = 1'b0;
    logic [N-1:0]   vote = '0;
    logic [N*W-1:0] counts;
    logic [W-1:0]   invalid_cnt;
    logic [1:0]     state;
    logic           ballot_ready, vote_ack, vote_rej, tie, result_valid;
    logic [1:0]     winner;

    int n_chk = 0;
    int n_pass = 0;
    int mc[N];
    int minv;

    evm_ballot_unit #(.N_CAND(N), .CNT_W(W)) dut (
        .clk(clk), .reset(reset), .open_poll(open_poll), .close_poll(close_poll),
        .voter_en(voter_en), .vote(vote), .counts(counts), .invalid_cnt(invalid_cnt),
        .state(state), .ballot_ready(ballot_ready), .vote_ack(vote_ack), .vote_rej(vote_rej),
        .winner(winner), .tie(tie), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0]   pat;
        logic           ack;
        logic           rej;
        logic [N*W-1:0] cnt;   // nibble i = candidate i
        logic [W-1:0]   inv;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_open();
        open_poll = 1'b1; step(); open_poll = 1'b0;
    endtask

    task automatic arm();
        voter_en = 1'b1; step(); voter_en = 1'b0;
    endtask

    task automatic press(input logic [N-1:0] p);
        vote = p;
        repeat (LAT) step();
        step();
    endtask

    task automatic release_v();
        vote = '0;
        repeat (LAT + 1) step();
    endtask

    task automatic ballot(input logic [N-1:0] p, input logic eack, input logic erej, input string nm);
        arm();
        chk({nm, " ready"}, ballot_ready, 1'b1);
        press(p);
        chk({nm, " ack"}, vote_ack, eack);
        chk({nm, " rej"}, vote_rej, erej);
        chk({nm, " state"}, state, 2'd1);
        release_v();
        chk({nm, " ack drop"}, vote_ack, 1'b0);
    endtask

    function automatic logic [N*W-1:0] mpack();
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(mc[i]);
        return r;
    endfunction

    function automatic void mvote(input logic [N-1:0] p);
        if ($countones(p) == 1) begin
            for (int i = 0; i < N; i++)
                if (p[i] && mc[i] < SAT) mc[i]++;
        end else if (minv < SAT) minv++;
    endfunction

    function automatic int mwin();
        int b = 0;
        for (int i = 1; i < N; i++) if (mc[i] > mc[b]) b = i;
        return b;
    endfunction

    function automatic logic mtie();
        int n = 0;
        int b = mwin();
        for (int i = 0; i < N; i++) if (mc[i] == mc[b]) n++;
        return n > 1;
    endfunction

    task automatic mclear();
        for (int i = 0; i < N; i++) mc[i] = 0;
        minv = 0;
    endtask

    task automatic cast_model(input string nm);
        for (int i = 0; i < N; i++)
            for (int k = 0; k < mc[i]; k++) begin
                logic [N-1:0] p;
                p = '0;
                p[i] = 1'b1;
                ballot(p, 1'b1, 1'b0, nm);
            end
    endtask

    // From CLOSED or IDLE: open, build the given counts, close and time the scan.
    task automatic run_result(input int c0, c1, c2, c3, input int ew, input logic et, input string nm);
        do_open();
        mc[0] = c0; mc[1] = c1; mc[2] = c2; mc[3] = c3;
        cast_model(nm);
        chk({nm, " counts"}, counts, mpack());
        close_poll = 1'b1; step(); close_poll = 1'b0;
        chk({nm, " closed"}, state, 2'd3);
        chk({nm, " rv at c"}, result_valid, 1'b0);
        repeat (N - 1) step();
        chk({nm, " rv at c+N-1"}, result_valid, 1'b0);
        step();
        chk({nm, " rv at c+N"}, result_valid, 1'b1);
        chk({nm, " winner"}, winner, ew);
        chk({nm, " tie"}, tie, et);
        step();
        chk({nm, " rv hold"}, result_valid, 1'b1);
        chk({nm, " winner hold"}, winner, ew);
    endtask

    initial begin
        tbl[0] = '{4'b0010, 1'b1, 1'b0, 16'h0010, 4'd0};
        tbl[1] = '{4'b0010, 1'b1, 1'b0, 16'h0020, 4'd0};
        tbl[2] = '{4'b0010, 1'b1, 1'b0, 16'h0030, 4'd0};
        tbl[3] = '{4'b0101, 1'b0, 1'b1, 16'h0030, 4'd1};
        tbl[4] = '{4'b1000, 1'b1, 1'b0, 16'h1030, 4'd1};
        tbl[5] = '{4'b1111, 1'b0, 1'b1, 16'h1030, 4'd2};
        tbl[6] = '{4'b0001, 1'b1, 1'b0, 16'h1031, 4'd2};
        tbl[7] = '{4'b0110, 1'b0, 1'b1, 16'h1031, 4'd3};

        repeat (2) step();
        chk("reset state", state, 2'd0);
        chk("reset counts", counts, 16'h0);
        chk("reset rv", result_valid, 1'b0);
        reset = 1'b1;
        step();

        do_open();
        chk("open state", state, 2'd1);
        for (int i = 0; i < 8; i++) begin
            ballot(tbl[i].pat, tbl[i].ack, tbl[i].rej, $sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d counts", i), counts, tbl[i].cnt);
            chk($sformatf("tbl%0d invalid", i), invalid_cnt, tbl[i].inv);
        end

        // press without arming: ignored
        press(4'b0101);
        chk("unarmed rej", vote_rej, 1'b0);
        chk("unarmed inv", invalid_cnt, 4'd3);
        release_v();

        // held button across arming
        vote = 4'b0001;
        repeat (LAT + 2) step();
        arm();
        repeat (3) step();
        chk("held ack", vote_ack, 1'b0);
        chk("held state", state, 2'd2);
        chk("held counts", counts, 16'h1031);
        release_v();
        press(4'b0001);
        chk("repress ack", vote_ack, 1'b1);
        chk("repress counts", counts, 16'h1032);
        release_v();

        // voter_en while ARMED does not stack ballots
        arm(); arm();
        chk("double arm", state, 2'd2);
        press(4'b1000);
        chk("stack ack", vote_ack, 1'b1);
        release_v();
        press(4'b1000);
        chk("stack 2nd ack", vote_ack, 1'b0);
        chk("stack counts", counts, 16'h2032);
        release_v();

        do_open();
        chk("open in OPEN", counts, 16'h2032);
        chk("open in OPEN st", state, 2'd1);

        // close beats a same-cycle rise
        arm();
        close_poll = 1'b1; vote = 4'b0100; step(); close_poll = 1'b0;
        chk("close beats state", state, 2'd3);
        chk("close beats ack", vote_ack, 1'b0);
        release_v();
        repeat (N) step();
        chk("close beats counts", counts, 16'h2032);
        chk("scan1 rv", result_valid, 1'b1);
        chk("scan1 winner", winner, 2'd1);
        chk("scan1 tie", tie, 1'b0);

        run_result(2, 5, 5, 1, 1, 1'b1, "r2551");
        run_result(2, 6, 5, 1, 1, 1'b0, "r2651");
        run_result(0, 0, 0, 0, 0, 1'b1, "rzero");

        do_open();
        chk("reopen rv", result_valid, 1'b0);
        chk("reopen counts", counts, 16'h0);
        chk("reopen inv", invalid_cnt, 4'd0);
        for (int k = 0; k < 16; k++) ballot(4'b0100, 1'b1, 1'b0, $sformatf("sat%0d", k));
        chk("sat counts", counts, 16'h0F00);

        close_poll = 1'b1; step(); close_poll = 1'b0;
        for (int r = 0; r < 3; r++) begin
            do_open();
            mclear();
            for (int k = 0; k < 40; k++) begin
                logic [N-1:0] p;
                p = N'($urandom_range(1, 15));
                ballot(p, $countones(p) == 1, $countones(p) != 1, $sformatf("rnd%0d_%0d", r, k));
                mvote(p);
                chk("rnd counts", counts, mpack());
                chk("rnd invalid", invalid_cnt, minv);
            end
            close_poll = 1'b1; step(); close_poll = 1'b0;
            repeat (N) step();
            chk("rnd rv", result_valid, 1'b1);
            chk("rnd winner", winner, mwin());
            chk("rnd tie", tie, mtie());
        end

        // asynchronous reset mid-ballot
        do_open();
        mclear();
        mc[0] = 3; mc[1] = 1; mc[3] = 2;
        cast_model("pre-reset");
        ballot(4'b0011, 1'b0, 1'b1, "pre-reset bad");
        chk("pre-reset counts", counts, 16'h2013);
        arm();
        #1 reset = 1'b0;
        #1;
        chk("async state", state, 2'd0);
        chk("async counts", counts, 16'h0);
        chk("async inv", invalid_cnt, 4'd0);
        chk("async ready", ballot_ready, 1'b0);
        chk("async ack", vote_ack, 1'b0);
        chk("async rv", result_valid, 1'b0);
        chk("async winner", {winner, tie}, 3'd0);
        step();
        reset = 1'b1;
        step();
        chk("post-reset state", state, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
